// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, load-latency bounds.
// Pure declarations, no logic.
package dmem_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the load/store unit (master) and dmem_ctrl (slave).
// Request is valid/ready; response is a one-cycle rsp_valid pulse with no backpressure.
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dmem_align.sv
// Lane steering for sub-word accesses: byte enables and replicated store data, load lane extract
// with sign/zero extension, and misalignment detection. Purely combinational, no backpressure.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign shifted    = rword >> {addr_lo, 3'b000};
  assign misaligned = ((size == SZ_H) && addr_lo[0]) ||
                      ((size == SZ_W) && (addr_lo != 2'b00));

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'd0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        be        = 4'b1111;
        rdata_ext = rword;
      end
      default: begin
        be        = 4'b0000;
        rdata_ext = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Word-organised data RAM behind a valid/ready request port; stores and errors respond 1 cycle
// after accept, loads RD_LAT cycles after. req_ready drops only while a multi-cycle load waits.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16384,
  parameter int RD_LAT = 1
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] LAT_CNT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("dmem_ctrl: RD_LAT out of range");
  end

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] ld_q, ld_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic             accept;
  logic             misaligned;
  logic             range_err;
  logic             err;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [31:0]      rword;
  logic [31:0]      rdata_ext;

  assign bus.req_ready = (state_q != WAIT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept    = bus.req_valid && bus.req_ready;
  assign idx       = bus.req_addr[IDX_W+1:2];
  assign range_err = ((bus.req_addr >> ADDR_W) != 32'd0) ||
                     (32'(bus.req_addr[ADDR_W-1:2]) >= 32'(DEPTH));
  assign err       = misaligned || (bus.req_size == SZ_ILL) || range_err;
  // Combinational read of the array: a store written at the previous edge is already visible.
  assign rword     = mem[idx];

  dmem_align u_align (
    .size        (bus.req_size),
    .addr_lo     (bus.req_addr[1:0]),
    .is_unsigned (bus.req_unsigned),
    .wdata       (bus.req_wdata),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst_n && accept && bus.req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_d        = ld_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ld_q;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          // Response registers only move when a response is issued, so they hold across WAIT.
          if (!bus.req_we && !err && (RD_LAT > 1)) begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
            ld_d    = rdata_ext;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (bus.req_we || err) ? 32'd0 : rdata_ext;
            rsp_err_d   = err;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      ld_q        <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: back-to-back vector table on an RD_LAT=1 instance, plus
// latency and reset-abort sequences on an RD_LAT=3 instance.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst3_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_if bus1();
  dmem_if bus3();

  dmem_ctrl #(.ADDR_W(16), .DEPTH(16384), .RD_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  dmem_ctrl #(.ADDR_W(16), .DEPTH(16384), .RD_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (bus3)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  // Issue one request to the RD_LAT=3 instance and measure cycles from accept to response.
  task automatic op3(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic er, output int lat);
    int w;
    bus3.req_valid    = 1'b1;
    bus3.req_we       = we;
    bus3.req_size     = size;
    bus3.req_unsigned = uns;
    bus3.req_addr     = addr;
    bus3.req_wdata    = wdata;
    w = 0;
    while (!bus3.req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    bus3.req_valid = 1'b0;
    lat = 1;
    while (!bus3.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd = bus3.rsp_rdata;
    er = bus3.rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [6:1]  exp_rdy;
    logic [6:1]  exp_rsp;
    logic        seen;

    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_size = SZ_W; bus1.req_unsigned = 1'b0;
    bus1.req_addr = 32'd0; bus1.req_wdata = 32'd0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_size = SZ_W; bus3.req_unsigned = 1'b0;
    bus3.req_addr = 32'd0; bus3.req_wdata = 32'd0;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    check("rst_ready", 32'(bus1.req_ready), 32'd1);
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    check("rst_rdata", bus1.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus1.rsp_err), 32'd0);
    check("rst3_ready", 32'(bus3.req_ready), 32'd1);

    vecs.push_back(mk("sw_10",     1, SZ_W,   0, 32'h0000_0010, 32'h1234_5678, 0, 32'h0));
    vecs.push_back(mk("lw_10",     0, SZ_W,   0, 32'h0000_0010, 32'h0,         0, 32'h1234_5678));
    vecs.push_back(mk("sw_20",     1, SZ_W,   0, 32'h0000_0020, 32'h80FF_7F01, 0, 32'h0));
    vecs.push_back(mk("lb_22",     0, SZ_B,   0, 32'h0000_0022, 32'h0,         0, 32'hFFFF_FFFF));
    vecs.push_back(mk("lbu_22",    0, SZ_B,   1, 32'h0000_0022, 32'h0,         0, 32'h0000_00FF));
    vecs.push_back(mk("lh_22",     0, SZ_H,   0, 32'h0000_0022, 32'h0,         0, 32'hFFFF_80FF));
    vecs.push_back(mk("lhu_20",    0, SZ_H,   1, 32'h0000_0020, 32'h0,         0, 32'h0000_7F01));
    vecs.push_back(mk("lb_21",     0, SZ_B,   0, 32'h0000_0021, 32'h0,         0, 32'h0000_007F));
    vecs.push_back(mk("sw_30",     1, SZ_W,   0, 32'h0000_0030, 32'hAAAA_AAAA, 0, 32'h0));
    vecs.push_back(mk("sb_31",     1, SZ_B,   0, 32'h0000_0031, 32'hFFFF_FF55, 0, 32'h0));
    vecs.push_back(mk("lw_30a",    0, SZ_W,   0, 32'h0000_0030, 32'h0,         0, 32'hAAAA_55AA));
    vecs.push_back(mk("sh_32",     1, SZ_H,   0, 32'h0000_0032, 32'hDEAD_1234, 0, 32'h0));
    vecs.push_back(mk("lw_30b",    0, SZ_W,   0, 32'h0000_0030, 32'h0,         0, 32'h1234_55AA));
    vecs.push_back(mk("lw_06_err", 0, SZ_W,   0, 32'h0000_0006, 32'h0,         1, 32'h0));
    vecs.push_back(mk("sh_13_err", 1, SZ_H,   0, 32'h0000_0013, 32'hBEEF_BEEF, 1, 32'h0));
    vecs.push_back(mk("lw_10_b",   0, SZ_W,   0, 32'h0000_0010, 32'h0,         0, 32'h1234_5678));
    vecs.push_back(mk("s11_err",   1, SZ_ILL, 0, 32'h0000_0010, 32'h0,         1, 32'h0));
    vecs.push_back(mk("lw_10_c",   0, SZ_W,   0, 32'h0000_0010, 32'h0,         0, 32'h1234_5678));
    vecs.push_back(mk("sw_hi_err", 1, SZ_W,   0, 32'h0001_0010, 32'h0,         1, 32'h0));
    vecs.push_back(mk("lw_hi_err", 0, SZ_W,   0, 32'h0001_0000, 32'h0,         1, 32'h0));
    vecs.push_back(mk("lw_10_d",   0, SZ_W,   0, 32'h0000_0010, 32'h0,         0, 32'h1234_5678));

    // One request per cycle, each response checked the cycle after its accept.
    for (int i = 0; i < vecs.size(); i++) begin
      bus1.req_valid    = 1'b1;
      bus1.req_we       = vecs[i].we;
      bus1.req_size     = vecs[i].size;
      bus1.req_unsigned = vecs[i].uns;
      bus1.req_addr     = vecs[i].addr;
      bus1.req_wdata    = vecs[i].wdata;
      check({vecs[i].name, "_ready"}, 32'(bus1.req_ready), 32'd1);
      @(negedge clk);
      check({vecs[i].name, "_vld"}, 32'(bus1.rsp_valid), 32'd1);
      check({vecs[i].name, "_err"}, 32'(bus1.rsp_err), 32'(vecs[i].err));
      check({vecs[i].name, "_rdata"}, bus1.rsp_rdata, vecs[i].rdata);
    end
    bus1.req_valid = 1'b0;
    @(negedge clk);
    check("idle_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    check("idle_busy", 32'(bus1.busy), 32'd0);

    op3(1'b1, SZ_W, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, rd, er, lat);
    check("l3_sw40_lat", 32'(lat), 32'd1);
    check("l3_sw40_err", 32'(er), 32'd0);
    op3(1'b1, SZ_W, 1'b0, 32'h0000_0044, 32'h0BAD_BEEF, rd, er, lat);
    check("l3_sw44_lat", 32'(lat), 32'd1);

    // Two loads back to back with the second held valid while the first is in flight.
    @(negedge clk);
    exp_rdy = 6'b100100;
    exp_rsp = 6'b100100;
    bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_size = SZ_W; bus3.req_unsigned = 1'b0;
    bus3.req_addr = 32'h0000_0040;
    check("l3_first_ready", 32'(bus3.req_ready), 32'd1);
    @(negedge clk);
    bus3.req_addr = 32'h0000_0044;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("l3_ready_c%0d", k), 32'(bus3.req_ready), 32'(exp_rdy[k]));
      check($sformatf("l3_busy_c%0d", k), 32'(bus3.busy), 32'd1);
      check($sformatf("l3_rsp_c%0d", k), 32'(bus3.rsp_valid), 32'(exp_rsp[k]));
      if (k == 3) check("l3_rdata_40", bus3.rsp_rdata, 32'hCAFE_F00D);
      if (k == 6) check("l3_rdata_44", bus3.rsp_rdata, 32'h0BAD_BEEF);
      if (k == 4) bus3.req_valid = 1'b0;
      @(negedge clk);
    end
    check("l3_end_busy", 32'(bus3.busy), 32'd0);

    // Reset while a load is waiting: its response must never appear.
    bus3.req_valid = 1'b1;
    bus3.req_addr  = 32'h0000_0040;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    check("rstmid_busy", 32'(bus3.busy), 32'd1);
    rst3_n = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    check("rstmid_ready", 32'(bus3.req_ready), 32'd1);
    check("rstmid_busy0", 32'(bus3.busy), 32'd0);
    seen = bus3.rsp_valid;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen = seen | bus3.rsp_valid;
    end
    check("rstmid_no_rsp", 32'(seen), 32'd0);
    op3(1'b0, SZ_W, 1'b0, 32'h0000_0044, 32'h0, rd, er, lat);
    check("rstmid_lw_lat", 32'(lat), 32'd3);
    check("rstmid_lw_rdata", rd, 32'h0BAD_BEEF);
    op3(1'b0, SZ_H, 1'b0, 32'h0000_0042, 32'h0, rd, er, lat);
    check("l3_lh42_rdata", rd, 32'hFFFF_CAFE);
    op3(1'b0, SZ_W, 1'b0, 32'h0000_0041, 32'h0, rd, er, lat);
    check("l3_err_lat", 32'(lat), 32'd1);
    check("l3_err_flag", 32'(er), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
